// File: rtl/control_fsm_p.sv
// ---------------------------------------------------------------------------
// control_fsm_p
//   Parametrised multicycle control unit for the 16-opcode ISA. Sequences
//   fetch / decode / execute and drives the datapath mux selects, the
//   register-file ports, the PC/IR/AR write strobes and the RAM write strobe.
//   Multicycle ALU operations use a start/done handshake guarded by a
//   timeout. RAM accesses wait on mem_ready. halt and err are sticky and
//   are cleared only by rst.
//
//   Output timing: every output is a register. The actions a state performs
//   are loaded on the clock edge that leaves that state, so they are visible
//   during the following cycle. The exception is write_ram: it is set on
//   entry to ST3 and held while ST3 waits, so the RAM sees the strobe in the
//   same cycles in which mem_ready is sampled.
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   instr [IW]           IR contents. op / rd / rs / imm / tgt fields are
//                        taken from fixed bit positions.
//   z                    ALU zero flag, sampled by JZ in its execute cycle
//   alu_done             one-cycle ALU result-valid pulse (used only in AWAIT)
//   mem_ready            RAM access complete (used only in MRD / ST3)
//   alu_op [3]           001 add, 010 sub, 011 mul, 100 div, 101 mod, 000 idle
//   alu_start            one-cycle pulse that launches an ALU operation
//   m1 [2]               register write-data select: 00 zero, 01 RAM,
//                        10 alpha, 11 ALU
//   m2                   AR/RAM select (0 load, 1 store)
//   m3                   PC select (0 gamma, 1 PC+1)
//   m4                   AR select (0 rpa, 1 alpha)
//   w_pc, w_ir, w_ar     PC / IR / AR write strobes
//   rpa, rpb [RAW]       register read ports
//   wpn [RAW]            register write port
//   write_en             register write strobe
//   write_ram            RAM write strobe
//   alpha [IMMW]         immediate driven to the datapath
//   gamma [JMPW]         jump target
//   halt, err            sticky status flags
// ---------------------------------------------------------------------------
module control_fsm_p #(
   parameter int OPW     = 4,
   parameter int RAW     = 5,
   parameter int IMMW    = 12,
   parameter int JMPW    = 6,
   parameter int ONE_REG = 19,
   parameter int ALU_TMO = 16,
   parameter int IW      = OPW + RAW + IMMW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IW-1:0]   instr,
   input  logic            z,
   input  logic            alu_done,
   input  logic            mem_ready,
   output logic [2:0]      alu_op,
   output logic            alu_start,
   output logic [1:0]      m1,
   output logic            m2,
   output logic            m3,
   output logic            m4,
   output logic            w_pc,
   output logic            w_ir,
   output logic            w_ar,
   output logic [RAW-1:0]  rpa,
   output logic [RAW-1:0]  rpb,
   output logic [RAW-1:0]  wpn,
   output logic            write_en,
   output logic            write_ram,
   output logic [IMMW-1:0] alpha,
   output logic [JMPW-1:0] gamma,
   output logic            halt,
   output logic            err
);

   // ------------------------------------------------------------------------
   // Opcode map
   // ------------------------------------------------------------------------
   localparam logic [OPW-1:0] OP_ILL  = OPW'(4'h0);
   localparam logic [OPW-1:0] OP_TERM = OPW'(4'h1);
   localparam logic [OPW-1:0] OP_CLR  = OPW'(4'h2);
   localparam logic [OPW-1:0] OP_WRI  = OPW'(4'h3);
   localparam logic [OPW-1:0] OP_LDI  = OPW'(4'h4);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(4'h5);
   localparam logic [OPW-1:0] OP_LD   = OPW'(4'h6);
   localparam logic [OPW-1:0] OP_MV   = OPW'(4'h7);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(4'h8);
   localparam logic [OPW-1:0] OP_INC  = OPW'(4'h9);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(4'hA);
   localparam logic [OPW-1:0] OP_JZ   = OPW'(4'hB);
   localparam logic [OPW-1:0] OP_JMP  = OPW'(4'hC);
   localparam logic [OPW-1:0] OP_ST   = OPW'(4'hD);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(4'hE);
   localparam logic [OPW-1:0] OP_MOD  = OPW'(4'hF);

   localparam logic [2:0] ALU_IDLE = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_MUL  = 3'b011;
   localparam logic [2:0] ALU_DIV  = 3'b100;
   localparam logic [2:0] ALU_MOD  = 3'b101;

   localparam logic [1:0] M1_ZERO  = 2'b00;
   localparam logic [1:0] M1_RAM   = 2'b01;
   localparam logic [1:0] M1_ALPHA = 2'b10;
   localparam logic [1:0] M1_ALU   = 2'b11;

   // The counter must reach ALU_TMO-1; one extra value of headroom keeps the
   // width valid for ALU_TMO = 1.
   localparam int CW = $clog2(ALU_TMO + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(ALU_TMO - 1);

   typedef enum logic [3:0] {
      S_FETCH1,
      S_FETCH2,
      S_DECODE,
      S_EXEC,
      S_MRD,
      S_MWB,
      S_ST2,
      S_ST3,
      S_AWAIT,
      S_HALT
   } state_t;

   state_t         state;
   logic [CW-1:0]  tmo_cnt;

   // ------------------------------------------------------------------------
   // Instruction fields. imm overlaps rs, and tgt overlaps rd/rs; each
   // opcode uses only the fields that are meaningful for it.
   // ------------------------------------------------------------------------
   logic [OPW-1:0]  op;
   logic [RAW-1:0]  rd;
   logic [RAW-1:0]  rs;
   logic [IMMW-1:0] imm;
   logic [JMPW-1:0] tgt;

   assign op  = instr[IW-1 -: OPW];
   assign rd  = instr[IW-OPW-1 -: RAW];
   assign rs  = instr[IW-OPW-RAW-1 -: RAW];
   assign imm = instr[IMMW-1:0];
   assign tgt = instr[IW-OPW-1 -: JMPW];

   // Maps the two-operand ALU opcodes to the ALU function code. Any opcode
   // not listed returns idle, which the execute state treats as illegal.
   function automatic logic [2:0] alu_code(input logic [OPW-1:0] o);
      case (o)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_MUL:  return ALU_MUL;
         OP_DIV:  return ALU_DIV;
         OP_MOD:  return ALU_MOD;
         default: return ALU_IDLE;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Sequencer. Strobes default low on every cycle. Selects and register
   // ports keep their last value unless a state rewrites them.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH1;
         tmo_cnt   <= '0;
         alu_op    <= ALU_IDLE;
         alu_start <= 1'b0;
         m1        <= M1_ZERO;
         m2        <= 1'b0;
         m3        <= 1'b1;
         m4        <= 1'b0;
         w_pc      <= 1'b0;
         w_ir      <= 1'b0;
         w_ar      <= 1'b0;
         rpa       <= '0;
         rpb       <= '0;
         wpn       <= '0;
         write_en  <= 1'b0;
         write_ram <= 1'b0;
         alpha     <= '0;
         gamma     <= '0;
         halt      <= 1'b0;
         err       <= 1'b0;
      end else begin
         w_pc      <= 1'b0;
         w_ir      <= 1'b0;
         w_ar      <= 1'b0;
         write_en  <= 1'b0;
         write_ram <= 1'b0;
         alu_start <= 1'b0;

         case (state)
            S_FETCH1: begin
               w_ir  <= 1'b1;
               state <= S_FETCH2;
            end

            S_FETCH2: begin
               m3    <= 1'b1;
               w_pc  <= 1'b1;
               state <= S_DECODE;
            end

            // One cycle for the IR to settle before the opcode is acted on.
            S_DECODE: state <= S_EXEC;

            S_EXEC: begin
               state <= S_FETCH1;
               case (op)
                  OP_ILL: begin
                     err   <= 1'b1;
                     halt  <= 1'b1;
                     state <= S_HALT;
                  end
                  OP_TERM: begin
                     halt  <= 1'b1;
                     state <= S_HALT;
                  end
                  OP_CLR: begin
                     m1       <= M1_ZERO;
                     wpn      <= rd;
                     write_en <= 1'b1;
                  end
                  OP_WRI: begin
                     alpha    <= imm;
                     m1       <= M1_ALPHA;
                     wpn      <= rd;
                     write_en <= 1'b1;
                  end
                  OP_LDI: begin
                     alpha <= imm;
                     m4    <= 1'b1;
                     w_ar  <= 1'b1;
                     m2    <= 1'b0;
                     state <= S_MRD;
                  end
                  OP_LD: begin
                     rpa   <= rs;
                     m4    <= 1'b0;
                     w_ar  <= 1'b1;
                     m2    <= 1'b0;
                     state <= S_MRD;
                  end
                  OP_ST: begin
                     rpa   <= rs;
                     m4    <= 1'b0;
                     w_ar  <= 1'b1;
                     state <= S_ST2;
                  end
                  OP_MV: begin
                     rpa      <= rs;
                     m1       <= M1_ALU;
                     wpn      <= rd;
                     write_en <= 1'b1;
                  end
                  OP_JZ: begin
                     // z still holds the flag left by the previous ALU op.
                     if (z) begin
                        gamma <= tgt;
                        m3    <= 1'b0;
                        w_pc  <= 1'b1;
                     end
                  end
                  OP_JMP: begin
                     gamma <= tgt;
                     m3    <= 1'b0;
                     w_pc  <= 1'b1;
                  end
                  OP_INC: begin
                     rpa       <= rd;
                     rpb       <= RAW'(ONE_REG);
                     alu_op    <= ALU_ADD;
                     alu_start <= 1'b1;
                     tmo_cnt   <= '0;
                     state     <= S_AWAIT;
                  end
                  default: begin
                     if (alu_code(op) != ALU_IDLE) begin
                        rpa       <= rd;
                        rpb       <= rs;
                        alu_op    <= alu_code(op);
                        alu_start <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= S_AWAIT;
                     end else begin
                        // Only reachable when OPW is wider than the ISA.
                        err   <= 1'b1;
                        halt  <= 1'b1;
                        state <= S_HALT;
                     end
                  end
               endcase
            end

            S_MRD: begin
               if (mem_ready) state <= S_MWB;
            end

            S_MWB: begin
               m1       <= M1_RAM;
               wpn      <= rd;
               write_en <= 1'b1;
               state    <= S_FETCH1;
            end

            // write_ram is raised here so it is already high in the first
            // ST3 cycle, when mem_ready is first sampled.
            S_ST2: begin
               rpa       <= rd;
               m2        <= 1'b1;
               write_ram <= 1'b1;
               state     <= S_ST3;
            end

            S_ST3: begin
               if (mem_ready) state <= S_FETCH1;
               else           write_ram <= 1'b1;
            end

            // The write-back is issued on the edge that samples alu_done;
            // there is no separate write-back state. A done pulse in the
            // last allowed cycle still wins over the timeout.
            S_AWAIT: begin
               if (alu_done) begin
                  m1       <= M1_ALU;
                  wpn      <= rd;
                  write_en <= 1'b1;
                  alu_op   <= ALU_IDLE;
                  state    <= S_FETCH1;
               end else if (tmo_cnt == TMO_LAST) begin
                  err    <= 1'b1;
                  halt   <= 1'b1;
                  alu_op <= ALU_IDLE;
                  state  <= S_HALT;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            S_HALT: begin
               halt  <= 1'b1;
               state <= S_HALT;
            end

            default: state <= S_FETCH1;
         endcase
      end
   end

endmodule

// File: tb/tb_control_fsm_p.sv
// ---------------------------------------------------------------------------
// tb_control_fsm_p
//   Self-checking bench for control_fsm_p. Each instruction is described as
//   an expected cycle timeline, counted from the cycle in which w_ir is seen
//   (c = 0). The timeline is worked out from the ISA rules:
//     c=0 w_ir, c=1 w_pc, c=2 decode, c=3 first execute action.
//   Multicycle instructions stretch this timeline by the RAM or ALU wait
//   the bench chooses. Inputs that the design must ignore (mem_ready and
//   alu_done outside their windows) are randomised.
// ---------------------------------------------------------------------------
module tb_control_fsm_p;
   localparam int OPW = 4, RAW = 5, IMMW = 12, JMPW = 6;
   localparam int ONE_REG = 19, ALU_TMO = 16, IW = 21;

   logic            clk = 1'b0;
   logic            rst, z, alu_done, mem_ready;
   logic [IW-1:0]   instr;
   logic [2:0]      alu_op;
   logic            alu_start, m2, m3, m4, w_pc, w_ir, w_ar;
   logic [1:0]      m1;
   logic [RAW-1:0]  rpa, rpb, wpn;
   logic            write_en, write_ram, halt, err;
   logic [IMMW-1:0] alpha;
   logic [JMPW-1:0] gamma;
   logic [5:0]      strb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign strb = {w_ir, w_pc, w_ar, write_en, write_ram, alu_start};

   control_fsm_p #(
      .OPW(OPW), .RAW(RAW), .IMMW(IMMW), .JMPW(JMPW),
      .ONE_REG(ONE_REG), .ALU_TMO(ALU_TMO)
   ) dut (
      .clk(clk), .rst(rst), .instr(instr), .z(z), .alu_done(alu_done),
      .mem_ready(mem_ready), .alu_op(alu_op), .alu_start(alu_start),
      .m1(m1), .m2(m2), .m3(m3), .m4(m4), .w_pc(w_pc), .w_ir(w_ir),
      .w_ar(w_ar), .rpa(rpa), .rpb(rpb), .wpn(wpn), .write_en(write_en),
      .write_ram(write_ram), .alpha(alpha), .gamma(gamma), .halt(halt),
      .err(err)
   );

   // Waits for the first fetch strobe after reset is released; it must come
   // in the very next cycle.
   task automatic sync_wir(input string tag);
      int n = 0;
      @(negedge clk);
      while (w_ir !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n != 0) begin
         bad++;
         $display("FAIL %s fetch_after_reset got=%0d cycles want=0", tag, n);
      end
   endtask

   task automatic reset_and_sync(input string tag);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({halt, err, strb, m3} !== {2'b00, 6'b0, 1'b1}) begin
         bad++;
         $display("FAIL %s reset_clear got=%b want=%b", tag, {halt, err, strb, m3}, 9'b000000001);
      end
      rst = 1'b0;
      sync_wir(tag);
   endtask

   // Runs one instruction starting at c=0, checking every cycle against the
   // timeline. alat: cycles from alu_start until alu_done (-1 = never).
   // mwait: cycles mem_ready is held low inside the RAM wait window.
   task automatic run_instr(input logic [IW-1:0] ins, input int alat,
                            input int mwait, input logic zv, input string tag);
      logic [3:0]  op;
      logic [4:0]  rd, rs, erpb;
      logic [11:0] imm;
      logic [5:0]  tgt, es;
      logic [2:0]  aop;
      logic [1:0]  em1;
      logic        is_alu, is_ld, is_st, is_jmp, taken, eh, ee;
      int          we_c, period, k, s, d, halt_c, err_c;

      op  = ins[20:17];
      rd  = ins[16:12];
      rs  = ins[11:7];
      imm = ins[11:0];
      tgt = ins[16:11];
      case (op)
         4'h5, 4'h9: aop = 3'd1;
         4'h8:       aop = 3'd2;
         4'hA:       aop = 3'd3;
         4'hE:       aop = 3'd4;
         4'hF:       aop = 3'd5;
         default:    aop = 3'd0;
      endcase
      is_alu = (aop != 0);
      is_ld  = (op == 4'h4) || (op == 4'h6);
      is_st  = (op == 4'hD);
      is_jmp = (op == 4'hB) || (op == 4'hC);
      taken  = (op == 4'hC) || (op == 4'hB && zv);
      erpb   = (op == 4'h9) ? 5'(ONE_REG) : rs;
      case (op)
         4'h2:       em1 = 2'b00;
         4'h3:       em1 = 2'b10;
         4'h4, 4'h6: em1 = 2'b01;
         default:    em1 = 2'b11;
      endcase

      we_c = -1; k = -1; s = -1; d = -1; halt_c = -1; err_c = -1; period = 4;
      if (op == 4'h2 || op == 4'h3 || op == 4'h7) we_c = 3;
      else if (is_ld) begin s = 3; k = s + mwait; we_c = k + 2; period = k + 3; end
      else if (is_st) begin s = 4; k = s + mwait; period = k + 2; end
      else if (is_alu) begin
         if (alat < 0) begin
            err_c = 3 + ALU_TMO; halt_c = err_c; period = err_c + 5;
         end else begin
            d = 3 + alat; we_c = d + 1; period = d + 2;
         end
      end
      else if (op == 4'h1) begin halt_c = 3; period = 9; end
      else if (op == 4'h0) begin halt_c = 3; err_c = 3; period = 9; end

      instr = ins;
      z     = zv;
      for (int c = 0; c < period; c++) begin
         if (c > 0) @(negedge clk);

         es = '0;
         if (c == 0) es[5] = 1'b1;
         if (c == 1 || (c == 3 && is_jmp && taken)) es[4] = 1'b1;
         if (c == 3 && (is_ld || is_st)) es[3] = 1'b1;
         if (c == we_c) es[2] = 1'b1;
         if (is_st && c >= 4 && c <= k) es[1] = 1'b1;
         if (c == 3 && is_alu) es[0] = 1'b1;
         total++;
         if (strb !== es) begin
            bad++;
            $display("FAIL %s strobes c=%0d got=%b want=%b", tag, c, strb, es);
         end

         eh = (halt_c >= 0 && c >= halt_c);
         ee = (err_c >= 0 && c >= err_c);
         total++;
         if ({halt, err} !== {eh, ee}) begin
            bad++;
            $display("FAIL %s halt_err c=%0d got=%b want=%b", tag, c, {halt, err}, {eh, ee});
         end

         if (c == 1) begin
            total++;
            if (m3 !== 1'b1) begin bad++; $display("FAIL %s pc_inc_sel got=%b want=1", tag, m3); end
         end
         if (c == we_c) begin
            total++;
            if ({wpn, m1} !== {rd, em1}) begin
               bad++;
               $display("FAIL %s writeback got wpn=%0d m1=%b want wpn=%0d m1=%b", tag, wpn, m1, rd, em1);
            end
            if (op == 4'h3) begin
               total++;
               if (alpha !== imm) begin bad++; $display("FAIL %s wri_alpha got=%h want=%h", tag, alpha, imm); end
            end
            if (op == 4'h7) begin
               total++;
               if (rpa !== rs) begin bad++; $display("FAIL %s mv_rpa got=%0d want=%0d", tag, rpa, rs); end
            end
         end
         if (c == 3 && (is_ld || is_st)) begin
            total++;
            if (op == 4'h4) begin
               if ({m4, m2, alpha} !== {1'b1, 1'b0, imm}) begin
                  bad++;
                  $display("FAIL %s ldi_addr got m4=%b m2=%b alpha=%h want m4=1 m2=0 alpha=%h", tag, m4, m2, alpha, imm);
               end
            end else if ({m4, rpa} !== {1'b0, rs} || (is_ld && m2 !== 1'b0)) begin
               bad++;
               $display("FAIL %s addr got m4=%b m2=%b rpa=%0d want m4=0 rpa=%0d", tag, m4, m2, rpa, rs);
            end
         end
         if (is_st && c >= 4 && c <= k) begin
            total++;
            if ({rpa, m2} !== {rd, 1'b1}) begin
               bad++;
               $display("FAIL %s st_data c=%0d got rpa=%0d m2=%b want rpa=%0d m2=1", tag, c, rpa, m2, rd);
            end
         end
         if (c == 3 && is_alu) begin
            total++;
            if ({alu_op, rpa, rpb} !== {aop, rd, erpb}) begin
               bad++;
               $display("FAIL %s alu_launch got op=%0d a=%0d b=%0d want op=%0d a=%0d b=%0d", tag, alu_op, rpa, rpb, aop, rd, erpb);
            end
         end
         if (c == 3 && is_jmp && taken) begin
            total++;
            if ({gamma, m3} !== {tgt, 1'b0}) begin
               bad++;
               $display("FAIL %s jump got gamma=%h m3=%b want gamma=%h m3=0", tag, gamma, m3, tgt);
            end
         end

         // Inputs for this cycle; anything outside a wait window is noise.
         if ((is_ld || is_st) && c >= s && c <= k) mem_ready = (c == k);
         else mem_ready = 1'($urandom_range(0, 1));
         if (is_alu && c >= 3 && (alat < 0 ? c < err_c : c <= d)) alu_done = (c == d);
         else alu_done = 1'($urandom_range(0, 1));
      end
      if (halt_c < 0) @(negedge clk);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      instr = IW'($urandom);
      repeat (3) @(negedge clk);
      total++;
      if ({strb, halt, err, m3} !== 9'b000000001) begin
         bad++;
         $display("FAIL reset_flags got=%b want=%b", {strb, halt, err, m3}, 9'b000000001);
      end
      total++;
      if ({alu_op, m1, m2, m4, rpa, rpb, wpn, alpha, gamma} !== '0) begin
         bad++;
         $display("FAIL reset_selects got=%h want=0", {alu_op, m1, m2, m4, rpa, rpb, wpn, alpha, gamma});
      end
      rst = 1'b0;
      sync_wir("reset");
   endtask

   task automatic test_wri();
      run_instr({4'h3, 5'd3, 12'h0A5}, 0, 0, 1'b0, "wri");
   endtask

   task automatic test_add();
      run_instr({4'h5, 5'd1, 5'd2, 7'd0}, 3, 0, 1'b0, "add");
      run_instr({4'h9, 5'd7, 5'd2, 7'd0}, 0, 0, 1'b0, "inc");
   endtask

   task automatic test_st();
      run_instr({4'hD, 5'd4, 5'd5, 7'd0}, 0, 5, 1'b0, "st");
      run_instr({4'hD, 5'd9, 5'd11, 7'd0}, 0, 0, 1'b0, "st_fast");
   endtask

   task automatic test_ld();
      run_instr({4'h6, 5'd8, 5'd12, 7'd0}, 0, 0, 1'b0, "ld");
      run_instr({4'h4, 5'd2, 12'h7C3}, 0, 3, 1'b0, "ldi");
   endtask

   task automatic test_jz();
      run_instr({4'hB, 6'h2A, 11'h155}, 0, 0, 1'b1, "jz_taken");
      run_instr({4'hB, 6'h2A, 11'h0F0}, 0, 0, 1'b0, "jz_not");
      run_instr({4'hC, 6'h15, 11'h3FF}, 0, 0, 1'b0, "jmp");
   endtask

   task automatic test_random();
      logic [3:0] op;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(2, 15));
         run_instr({op, 17'($urandom)}, $urandom_range(0, 5), $urandom_range(0, 4),
                   1'($urandom_range(0, 1)), "rand");
      end
   endtask

   // Reset arriving while the controller waits for the ALU.
   task automatic test_rst_await();
      instr    = {4'hE, 5'd6, 5'd7, 7'd0};
      alu_done = 1'b0;
      repeat (6) @(negedge clk);
      total++;
      if (alu_op !== 3'd4) begin bad++; $display("FAIL rst_await_busy got=%0d want=4", alu_op); end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({strb, halt, err, m3, alu_op} !== {9'b000000001, 3'd0}) begin
         bad++;
         $display("FAIL rst_await_clear got=%b want=%b", {strb, halt, err, m3, alu_op}, 12'b000000001000);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (w_ir !== 1'b1) begin bad++; $display("FAIL rst_await_fetch got=%b want=1", w_ir); end
   endtask

   task automatic test_timeout();
      run_instr({4'hE, 5'd2, 5'd3, 7'd0}, -1, 0, 1'b0, "div_timeout");
      reset_and_sync("timeout_rst");
   endtask

   task automatic test_term();
      run_instr({4'h1, 17'h1ABCD}, 0, 0, 1'b0, "term");
      reset_and_sync("term_rst");
      run_instr({4'h0, 17'h00F0F}, 0, 0, 1'b0, "illegal");
      reset_and_sync("illegal_rst");
      run_instr({4'h3, 5'd30, 12'hFFF}, 0, 0, 1'b0, "wri_after");
   endtask

   initial begin
      rst       = 1'b1;
      instr     = '0;
      z         = 1'b0;
      alu_done  = 1'b0;
      mem_ready = 1'b0;
      test_reset();
      test_wri();
      test_add();
      test_st();
      test_ld();
      test_jz();
      test_random();
      test_rst_await();
      test_timeout();
      test_term();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
